tx_fifo_feeder: RTL

TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 77 +++++++
 rtl/tx_fifo_feeder.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit path.
package uart_pkg;

    localparam int DBIT_DEF   = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered occupancy flags; a write while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              rd_en,
    output logic [DBIT-1:0]   rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [DBIT-1:0]   mem_r [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_next_s;
    logic              full_r;
    logic              empty_r;
    logic              push_s;
    logic              pop_s;

    // Accepted push/pop and next occupancy
    always_comb begin
        pop_s        = rd_en && !empty_r;
        push_s       = wr_en && (!full_r || pop_s);
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + (ADDR_W+1)'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - (ADDR_W+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array; not reset since occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, count and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= count_next_s[ADDR_W];
            empty_r <= (count_next_s == {(ADDR_W+1){1'b0}});
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/tx_fifo_feeder.sv
// Feeds bytes from a FIFO to a UART transmitter, one start pulse per byte.
// Optional sticky overflow flag when TX_FIFO_OVF_EN is defined.
module tx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    input  logic              tx_done_tick
`ifdef TX_FIFO_OVF_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf
`endif
);

    tx_state_e         state_r;
    tx_state_e         state_next_s;
    logic              rd_en_s;
    logic [DBIT-1:0]   rd_data_s;
    logic [DBIT-1:0]   tx_din_r;
    logic              tx_start_r;
    logic              full_s;
    logic              empty_s;

    sync_fifo #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count)
    );

    // Next state and pop request
    always_comb begin
        state_next_s = state_r;
        rd_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    rd_en_s      = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_done_tick) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, byte register and start pulse (high only during LOAD)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tx_din_r   <= {DBIT{1'b0}};
            tx_start_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tx_start_r <= (state_next_s == ST_LOAD);
            if (rd_en_s) begin
                tx_din_r <= rd_data_s;
            end
        end
    end

`ifdef TX_FIFO_OVF_EN
    logic ovf_r;
    logic drop_s;

    assign drop_s = wr_en && full_s && !rd_en_s;

    // Sticky overflow; a drop outranks a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    assign ovf = ovf_r;
`endif

    assign full     = full_s;
    assign empty    = empty_s;
    assign tx_start = tx_start_r;
    assign tx_din   = tx_din_r;

endmodule
